// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine: one shared micro-rotation stage stepped over ITERS cycles.
// Latency: ITERS edges from the start-sampling edge to done; one result per ITERS+1 cycles.
// Backpressure: start is accepted only while ready; a start seen during a run is dropped.
module cordic_iter_ctrl #(
    parameter int ITERS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [4:0]  iter,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    // round(atan(2^-i) * 2^29); entry 2 is 131521918.29 and rounds down to 131521918.
    localparam logic [31:0] ATAN [32] = '{
        32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
        32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
        32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
        32'd131072,    32'd65536,     32'd32768,     32'd16384,
        32'd8192,      32'd4096,      32'd2048,      32'd1024,
        32'd512,       32'd256,       32'd128,       32'd64,
        32'd32,        32'd16,        32'd8,         32'd4,
        32'd2,         32'd1,         32'd0,         32'd0
    };

    state_t             state;
    logic [31:0]        xr, yr, zr;
    logic signed [31:0] xs, ys;
    logic [31:0]        x_nxt, y_nxt, z_nxt;

    // Zero residual angle takes the negative-rotation branch.
    always_comb begin
        xs = $signed(xr) >>> iter;
        ys = $signed(yr) >>> iter;
        if ($signed(zr) > 0) begin
            x_nxt = xr - ys;
            y_nxt = yr + xs;
            z_nxt = zr - ATAN[iter];
        end else begin
            x_nxt = xr + ys;
            y_nxt = yr - xs;
            z_nxt = zr + ATAN[iter];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            iter  <= 5'd0;
            xr    <= 32'd0;
            yr    <= 32'd0;
            zr    <= 32'd0;
            x_out <= 32'd0;
            y_out <= 32'd0;
            z_out <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        yr    <= y_in;
                        zr    <= z_in;
                        iter  <= 5'd0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    xr <= x_nxt;
                    yr <= y_nxt;
                    zr <= z_nxt;
                    if (iter == LAST) begin
                        x_out <= x_nxt;
                        y_out <= y_nxt;
                        z_out <= z_nxt;
                        done  <= 1'b1;
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        iter  <= 5'd0;
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboarded bench for cordic_iter_ctrl with ITERS = 16, 1 and 2 instances.
module tb_cordic_iter_ctrl;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        int          tol_xy;
        int          tol_z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s16, s1, s2;
    logic [31:0] xi16, yi16, zi16, xi1, yi1, zi1, xi2, yi2, zi2;
    logic        rdy16, bsy16, dn16, rdy1, bsy1, dn1, rdy2, bsy2, dn2;
    logic [4:0]  it16, it1, it2;
    logic [31:0] xo16, yo16, zo16, xo1, yo1, zo1, xo2, yo2, zo2;

    cordic_iter_ctrl #(.ITERS(16)) d16 (
        .clk(clk), .rst(rst), .start(s16), .x_in(xi16), .y_in(yi16), .z_in(zi16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .iter(it16),
        .x_out(xo16), .y_out(yo16), .z_out(zo16));

    cordic_iter_ctrl #(.ITERS(1)) d1 (
        .clk(clk), .rst(rst), .start(s1), .x_in(xi1), .y_in(yi1), .z_in(zi1),
        .ready(rdy1), .busy(bsy1), .done(dn1), .iter(it1),
        .x_out(xo1), .y_out(yo1), .z_out(zo1));

    cordic_iter_ctrl #(.ITERS(2)) d2 (
        .clk(clk), .rst(rst), .start(s2), .x_in(xi2), .y_in(yi2), .z_in(zi2),
        .ready(rdy2), .busy(bsy2), .done(dn2), .iter(it2),
        .x_out(xo2), .y_out(yo2), .z_out(zo2));

    exp_t q16[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t em;

    localparam int V1_X = 326016437;
    localparam int V1_Z = 281104953;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic bit near(input logic [31:0] a, input logic [31:0] e, input int tol);
        longint d;
        d = longint'($signed(a)) - longint'($signed(e));
        return (d <= longint'(tol)) && (d >= -longint'(tol));
    endfunction

    function automatic exp_t mk(input int x, input int y, input int z,
                                input int txy, input int tz, input int c);
        exp_t e;
        e.x = 32'(x);
        e.y = 32'(y);
        e.z = 32'(z);
        e.tol_xy = txy;
        e.tol_z = tz;
        e.cyc = c;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [31:0] xa,
                         input logic [31:0] ya, input logic [31:0] za,
                         input logic rdy, input logic bsy);
        check({tag, "_x_out"}, near(xa, e.x, e.tol_xy), longint'($signed(xa)), longint'($signed(e.x)));
        check({tag, "_y_out"}, near(ya, e.y, e.tol_xy), longint'($signed(ya)), longint'($signed(e.y)));
        check({tag, "_z_out"}, near(za, e.z, e.tol_z), longint'($signed(za)), longint'($signed(e.z)));
        check({tag, "_done_edge"}, cyc == e.cyc, cyc, e.cyc);
        check({tag, "_ready_with_done"}, rdy == 1'b1, rdy, 1);
        check({tag, "_busy_with_done"}, bsy == 1'b0, bsy, 0);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (dn16) begin
            check("d16_done_expected", q16.size() > 0, q16.size(), 1);
            if (q16.size() > 0) begin
                em = q16.pop_front();
                score("d16", em, xo16, yo16, zo16, rdy16, bsy16);
            end
        end
        if (dn1) begin
            check("d1_done_expected", q1.size() > 0, q1.size(), 1);
            if (q1.size() > 0) begin
                em = q1.pop_front();
                score("d1", em, xo1, yo1, zo1, rdy1, bsy1);
            end
        end
        if (dn2) begin
            check("d2_done_expected", q2.size() > 0, q2.size(), 1);
            if (q2.size() > 0) begin
                em = q2.pop_front();
                score("d2", em, xo2, yo2, zo2, rdy2, bsy2);
            end
        end
    end

    task automatic drain(input int max_cyc);
        int n;
        int left;
        n = 0;
        while ((q16.size() + q1.size() + q2.size()) != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        left = q16.size() + q1.size() + q2.size();
        check("drain_timeout", left == 0, left, 0);
        q16.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic go16(input int x, input int y, input int z);
        xi16 = 32'(x);
        yi16 = 32'(y);
        zi16 = 32'(z);
        s16 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int seen;
        rst = 1'b1;
        s16 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        xi16 = '0; yi16 = '0; zi16 = '0;
        xi1 = '0; yi1 = '0; zi1 = '0;
        xi2 = '0; yi2 = '0; zi2 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", rdy16 == 1'b1, rdy16, 1);
        check("rst_busy", bsy16 == 1'b0, bsy16, 0);
        check("rst_done", dn16 == 1'b0, dn16, 0);
        check("rst_iter", it16 == 5'd0, it16, 0);
        check("rst_x_out", xo16 == 32'd0, xo16, 0);
        rst = 1'b0;

        // ITERS=1: single positive-branch rotation
        @(negedge clk);
        xi1 = 32'd1000; yi1 = 32'd0; zi1 = 32'd1; s1 = 1'b1;
        q1.push_back(mk(1000, 1000, -421657427, 0, 0, cyc + 2));
        @(negedge clk);
        s1 = 1'b0;
        check("d1_busy_after_start", bsy1 == 1'b1, bsy1, 1);
        check("d1_ready_after_start", rdy1 == 1'b0, rdy1, 0);
        @(negedge clk);
        check("d1_busy_one_cycle", bsy1 == 1'b0, bsy1, 0);
        @(negedge clk);
        check("d1_done_width", dn1 == 1'b0, dn1, 0);

        // ITERS=2: zero/negative branch with arithmetic shift of a negative value
        xi2 = -32'sd8; yi2 = 32'd0; zi2 = -32'sd1; s2 = 1'b1;
        q2.push_back(mk(-12, 4, 172738512, 0, 0, cyc + 3));
        @(negedge clk);
        s2 = 1'b0;
        drain(20);

        // ITERS=16: rotate pre-scaled unit vector by pi/6
        @(negedge clk);
        go16(V1_X, 0, V1_Z);
        q16.push_back(mk(464943848, 268435456, 0, 32768, 16384, cyc + 17));
        @(negedge clk);
        s16 = 1'b0;
        repeat (7) @(negedge clk);
        check("d16_iter_mid", it16 == 5'd7, it16, 7);
        check("d16_busy_mid", bsy16 == 1'b1, bsy16, 1);
        check("d16_out_hold_mid", xo16 == 32'd0, xo16, 0);
        drain(30);
        @(negedge clk);
        check("d16_done_width", dn16 == 1'b0, dn16, 0);
        check("d16_ready_idle", rdy16 == 1'b1, rdy16, 1);
        check("d16_iter_idle", it16 == 5'd0, it16, 0);

        // Zero angle: first step takes the else branch, result is the gain-scaled x
        @(negedge clk);
        go16(536870912, 0, 0);
        q16.push_back(mk(884097682, 0, 0, 65536, 16384, cyc + 17));
        @(negedge clk);
        s16 = 1'b0;
        @(negedge clk);
        check("d16_yr_after_e1", d16.yr == 32'hE000_0000, longint'($signed(d16.yr)), -536870912);
        drain(30);

        // start held for 40 edges: accepted at E0, E17, E34
        @(negedge clk);
        go16(V1_X, 0, V1_Z);
        q16.push_back(mk(464943848, 268435456, 0, 32768, 16384, cyc + 17));
        q16.push_back(mk(464943848, 268435456, 0, 32768, 16384, cyc + 34));
        q16.push_back(mk(464943848, 268435456, 0, 32768, 16384, cyc + 51));
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 39) s16 = 1'b0;
            if (bsy16 == dn16) bad++;
            if (dn16 != ((k == 16) || (k == 33))) bad++;
        end
        check("b2b_busy_done_pattern", bad == 0, bad, 0);
        drain(30);

        // Reset after E5 discards the operation
        @(negedge clk);
        go16(V1_X, 0, V1_Z);
        @(negedge clk);
        s16 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", bsy16 == 1'b0, bsy16, 0);
        check("midrst_ready", rdy16 == 1'b1, rdy16, 1);
        check("midrst_x_out", xo16 == 32'd0, longint'($signed(xo16)), 0);
        check("midrst_y_out", yo16 == 32'd0, longint'($signed(yo16)), 0);
        check("midrst_z_out", zo16 == 32'd0, longint'($signed(zo16)), 0);
        check("midrst_iter", it16 == 5'd0, it16, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (dn16) seen++;
        end
        check("midrst_no_done", seen == 0, seen, 0);
        go16(V1_X, 0, V1_Z);
        q16.push_back(mk(464943848, 268435456, 0, 32768, 16384, cyc + 17));
        @(negedge clk);
        s16 = 1'b0;
        drain(30);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
